// File: rtl/int32_to_fp32_convert_pkg.sv
// Shared single-precision float definitions used by the integer-to-float converter
// and the neighbouring floating-point arithmetic blocks.
package int32_to_fp32_convert_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  localparam logic [FP_EXP_W-1:0] FP_BIAS        = 8'd127;
  localparam logic [FP_EXP_W-1:0] FP_EXP_INT_TOP = 8'd158;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/int32_to_fp32_convert_pack.sv
// Assembles an IEEE 754 single-precision word from its sign, biased exponent
// and stored fraction fields.
module int32_to_fp32_convert_pack
  import int32_to_fp32_convert_pkg::*;
(
  input  logic                 sign,
  input  logic [FP_EXP_W-1:0]  exp,
  input  logic [FP_FRAC_W-1:0] frac,
  output logic [31:0]          word
);

  assign word = {sign, exp, frac};

endmodule

// File: rtl/int32_to_fp32_convert.sv
// Sequential 32-bit integer to IEEE 754 single-precision converter: one
// normalising left shift per cycle, then round-to-nearest-even.
module int32_to_fp32_convert
  import int32_to_fp32_convert_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        inexact
);

  state_t               state;
  logic                 sign_r;
  logic [31:0]          a_r;
  logic [31:0]          mag;
  logic [FP_EXP_W-1:0]  exp_r;
  logic [FP_FRAC_W-1:0] mant_r;
  logic                 res_sign;
  logic [FP_EXP_W-1:0]  res_exp;

  logic [FP_FRAC_W-1:0] m;
  logic                 g_bit;
  logic                 r_bit;
  logic                 s_bit;
  logic                 round_up;
  logic [FP_FRAC_W-1:0] mant_next;
  logic [FP_EXP_W-1:0]  exp_next;

  assign m        = mag[30:8];
  assign g_bit    = mag[7];
  assign r_bit    = mag[6];
  assign s_bit    = |mag[5:0];
  assign round_up = g_bit & (r_bit | s_bit | m[0]);

  // A round-up of an all-ones fraction carries into the exponent.
  always_comb begin
    mant_next = m;
    exp_next  = exp_r;
    if (round_up && (&m)) begin
      mant_next = '0;
      exp_next  = exp_r + 8'd1;
    end else if (round_up) begin
      mant_next = m + 23'd1;
    end
  end

  // Result fields are only written on the zero path or the ROUND->DONE edge,
  // so `out` holds steady between conversions.
  int32_to_fp32_convert_pack u_pack (
    .sign (res_sign),
    .exp  (res_exp),
    .frac (mant_r),
    .word (out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sign_r   <= 1'b0;
      a_r      <= '0;
      mag      <= '0;
      exp_r    <= '0;
      mant_r   <= '0;
      res_sign <= 1'b0;
      res_exp  <= '0;
      inexact  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (a == 32'd0) begin
              res_sign <= 1'b0;
              res_exp  <= '0;
              mant_r   <= '0;
              inexact  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              sign_r <= SIGNED & a[31];
              a_r    <= a;
              state  <= ABS;
            end
          end
        end
        ABS: begin
          mag   <= sign_r ? (~a_r + 32'd1) : a_r;
          exp_r <= FP_EXP_INT_TOP;
          state <= NORM;
        end
        NORM: begin
          if (!mag[31]) begin
            mag   <= mag << 1;
            exp_r <= exp_r - 8'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          res_sign <= sign_r;
          res_exp  <= exp_next;
          mant_r   <= mant_next;
          exp_r    <= exp_next;
          inexact  <= g_bit | r_bit | s_bit;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
